mult_booth_seq_ctrl: RTL and testbench

//  Multi-cycle signed 32x32 multiplier controller (radix-2 Booth) for the processor's multdiv unit.

---
 rtl/mult_ctrl_pkg.sv | 27 ++
 rtl/adder_32bit_cas.sv | 25 ++
 rtl/mult_booth_seq_ctrl_booth_step.sv | 44 ++++
 rtl/mult_booth_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mult_booth_seq_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_ctrl_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_t;

    function automatic booth_t booth_sel(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/adder_32bit_cas.sv
// 32-bit carry-select adder: four 8-bit blocks, each precomputing both carry-in cases.
module adder_32bit_cas (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        ovf
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_blk
        logic [8:0] s0;
        logic [8:0] s1;
        assign s0 = {1'b0, in1[8*i +: 8]} + {1'b0, in2[8*i +: 8]};
        assign s1 = s0 + 9'd1;
        assign sum[8*i +: 8] = c[i] ? s1[7:0] : s0[7:0];
        assign c[i+1]        = c[i] ? s1[8]   : s0[8];
    end

    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf = (in1[31] == in2[31]) && (sum[31] != in1[31]);

endmodule

// File: rtl/mult_booth_seq_ctrl_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into hi, then arithmetic shift right.
module booth_step
    import mult_ctrl_pkg::*;
(
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic        q_m1,
    input  logic [31:0] m,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo,
    output logic        next_q_m1
);
    booth_t      sel;
    logic [31:0] in2;
    logic        cin;
    logic [31:0] sum;
    logic        ovf;

    assign sel = booth_sel(lo[0], q_m1);

    always_comb begin
        in2 = '0;
        cin = 1'b0;
        case (sel)
            BOOTH_ADD: begin in2 = m;  cin = 1'b0; end
            BOOTH_SUB: begin in2 = ~m; cin = 1'b1; end
            default:   begin in2 = '0; cin = 1'b0; end
        endcase
    end

    adder_32bit_cas u_adder (
        .in1 (hi),
        .in2 (in2),
        .cin (cin),
        .sum (sum),
        .ovf (ovf)
    );

    // The shifted-in bit is the true 33-bit sign, so +-M never loses magnitude.
    assign next_hi   = {sum[31] ^ ovf, sum[31:1]};
    assign next_lo   = {sum[0], lo[31:1]};
    assign next_q_m1 = lo[0];

endmodule

// File: rtl/mult_booth_seq_ctrl.sv
// Multi-cycle signed 32x32 Booth multiplier controller with start/ready/valid handshake.
// Optional MULT_HI_OUT_EN exposes the upper product word as result_hi.
module mult_booth_seq_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             in_ready,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic             data_exception,
    output logic [1:0]       dbg_state
`ifdef MULT_HI_OUT_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);
    // Handshake: a request is taken on a clock edge where start && in_ready;
    // result_valid/result/data_exception then hold until the next taken request or reset.

    state_t           state, next_state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] hi, lo;
    logic             q_m1;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             step_q_m1;
    logic             accept;
    logic             step;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        step         = 1'b0;
        in_ready     = 1'b1;
        result_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                accept = start;
                if (start) next_state = ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b0;
                step     = 1'b1;
                if (count == CNT_W'(WIDTH - 1)) next_state = ST_DONE;
            end
            ST_DONE: begin
                result_valid = 1'b1;
                accept       = start;
                if (start) next_state = ST_RUN;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    booth_step u_step (
        .hi        (hi),
        .lo        (lo),
        .q_m1      (q_m1),
        .m         (m_reg),
        .next_hi   (step_hi),
        .next_lo   (step_lo),
        .next_q_m1 (step_q_m1)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            m_reg <= '0;
            hi    <= '0;
            lo    <= '0;
            q_m1  <= 1'b0;
        end else if (accept) begin
            count <= '0;
            m_reg <= op_a;
            hi    <= '0;
            lo    <= op_b;
            q_m1  <= 1'b0;
        end else if (step) begin
            count <= count + 1'b1;
            hi    <= step_hi;
            lo    <= step_lo;
            q_m1  <= step_q_m1;
        end
    end

    assign result         = lo;
    assign data_exception = (hi != {WIDTH{lo[WIDTH-1]}});
    assign dbg_state      = state;

`ifdef MULT_HI_OUT_EN
    assign result_hi = hi;
`endif

endmodule

// File: tb/tb_mult_booth_seq_ctrl.sv
// Directed self-checking bench for mult_booth_seq_ctrl (optionally with MULT_HI_OUT_EN).
module tb_mult_booth_seq_ctrl;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        in_ready;
    logic        result_valid;
    logic [31:0] result;
    logic        data_exception;
    logic [1:0]  dbg_state;
`ifdef MULT_HI_OUT_EN
    logic [31:0] result_hi;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int          cycles;

    mult_booth_seq_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .op_a           (op_a),
        .op_b           (op_b),
        .in_ready       (in_ready),
        .result_valid   (result_valid),
        .result         (result),
        .data_exception (data_exception),
        .dbg_state      (dbg_state)
`ifdef MULT_HI_OUT_EN
        ,
        .result_hi      (result_hi)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one request; returns #1 after the accepting edge
    task automatic do_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // count rising edges until result_valid, bounded
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            n++;
            if (result_valid) break;
        end
        if (!result_valid) begin
            total++;
            bad++;
            $error("FAIL timeout observed=%0d expected=valid", n);
        end
    endtask

    task automatic check_result(input string tag, input logic exp_exc);
        exp_v = exp_q.pop_front();
        check({tag, "_result"}, result, exp_v);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
        check({tag, "_valid"}, {31'd0, result_valid}, 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op_a    = '0;
        op_b    = '0;
        #12;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // 3 * 5 with latency check
        exp_q.push_back(32'h0000000F);
        do_start(32'd3, 32'd5);
        check("t1_busy", {31'd0, in_ready}, 32'd0);
        check("t1_state", {30'd0, dbg_state}, 32'd1);
        wait_valid(cycles);
        check("t1_latency", cycles, 32'd32);
        check_result("t1", 1'b0);
        check("t1_ready", {31'd0, in_ready}, 32'd1);

        // -7 * 6
        exp_q.push_back(32'hFFFFFFD6);
        do_start(32'hFFFFFFF9, 32'd6);
        wait_valid(cycles);
        check_result("t2", 1'b0);

        // most-negative multiplicand times -1
        exp_q.push_back(32'h80000000);
        do_start(32'h80000000, 32'hFFFFFFFF);
        wait_valid(cycles);
        check_result("t3", 1'b1);
`ifdef MULT_HI_OUT_EN
        check("t3_hi", result_hi, 32'h00000000);
`endif

        // 2^16 * 2^16
        exp_q.push_back(32'h00000000);
        do_start(32'h00010000, 32'h00010000);
        wait_valid(cycles);
        check_result("t4", 1'b1);
`ifdef MULT_HI_OUT_EN
        check("t4_hi", result_hi, 32'h00000001);
`endif

        // start during RUN is ignored; operand changes after accept too
        exp_q.push_back(32'd18);
        do_start(32'd2, 32'd9);
        repeat (10) @(posedge clock);
        #1;
        start = 1'b1;
        op_a  = 32'd100;
        op_b  = 32'd100;
        @(posedge clock);
        #1;
        start = 1'b0;
        op_a  = 32'hDEADBEEF;
        op_b  = 32'h12345678;
        wait_valid(cycles);
        check("t5_latency", cycles, 32'd21);
        check_result("t5", 1'b0);

        // async reset mid-RUN aborts
        do_start(32'h00001234, 32'h00005678);
        repeat (20) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5r_valid", {31'd0, result_valid}, 32'd0);
        check("t5r_ready", {31'd0, in_ready}, 32'd1);
        check("t5r_state", {30'd0, dbg_state}, 32'd0);
        check("t5r_result", result, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(posedge clock);
        #1;
        check("t5r_idle_valid", {31'd0, result_valid}, 32'd0);

        // back-to-back: restart in the first DONE cycle
        exp_q.push_back(32'd20);
        do_start(32'd4, 32'd5);
        wait_valid(cycles);
        check_result("t6a", 1'b0);
        exp_q.push_back(32'hFFFFFFFE);
        start = 1'b1;
        op_a  = 32'h7FFFFFFF;
        op_b  = 32'd2;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("t6_valid_drop", {31'd0, result_valid}, 32'd0);
        check("t6_busy", {31'd0, in_ready}, 32'd0);
        wait_valid(cycles);
        check("t6_latency", cycles, 32'd32);
        check_result("t6b", 1'b1);
`ifdef MULT_HI_OUT_EN
        check("t6_hi", result_hi, 32'h00000000);
`endif

        // DONE holds while no new request arrives
        repeat (3) @(posedge clock);
        #1;
        check("hold_valid", {31'd0, result_valid}, 32'd1);
        check("hold_result", result, 32'hFFFFFFFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
